ram_master: RTL and testbench
=============================

Name: ram_master

Overview:
- Initiator-side controller for the 256x32 single-port synchronous RAM (`ram`).
- Accepts one 64-bit load/store request from the core over a valid/ready handshake.
- Sequences it as two 32-bit RAM accesses: high word at addr_hi, low word at addr_lo.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Sits between the processor datapath and `ram`; it is the only driver of the RAM's addr/wr/wdata/rd pins.

Parameters:
- ADDR_W, 9: RAM address width, matches the `ram` port.
- WORD_W, 32: RAM data word width. The request/response width is 2*WORD_W.
- RAM_DEPTH, 256: number of implemented RAM words. Used only when RAM_BOUND_CHECK_EN is defined.

Ports:
- clock  in  1  rising-edge clock, shared with `ram`.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr_hi  in  ADDR_W  RAM address of the high word [63:32].
- req_addr_lo  in  ADDR_W  RAM address of the low word [31:0].
- req_wdata  in  2*WORD_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  2*WORD_W  load data; 0 for stores.
- rsp_err  out  1  out-of-range access. Only produced under RAM_BOUND_CHECK_EN, otherwise tied 0.
- ram_addr  out  ADDR_W  to `ram` addr.
- ram_wr  out  1  to `ram` wr.
- ram_wdata  out  WORD_W  to `ram` wdata.
- ram_rd  out  1  to `ram` rd.
- ram_rdata  in  WORD_W  from `ram` rdata. Registered, 1-cycle latency, Z when rd is low.

Behaviour:
- Single clock `clock`. Reset is synchronous and active-low on `reset_n`.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - ram_addr = 0, ram_wr = 0, ram_rd = 0, ram_wdata = 0.
- All ram_* outputs and rsp_* outputs are registered or decoded from state only. No combinational path from req_* to ram_*.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at an edge: latch we, addr_hi, addr_lo and wdata, then go to HI.
- HI (req_ready = 0):
  - Drive ram_addr = addr_hi.
  - Store: ram_wr = 1, ram_wdata = wdata[63:32]. Load: ram_rd = 1.
  - Go to LO.
- LO:
  - Drive ram_addr = addr_lo.
  - Store: ram_wr = 1, ram_wdata = wdata[31:0], then go to RESP.
  - Load: ram_rd = 1. At the edge ending LO, capture ram_rdata into rdata[63:32], then go to CAP.
- CAP (load only):
  - ram_rd = 0, ram_wr = 0.
  - At the edge ending CAP, capture ram_rdata into rdata[31:0], then go to RESP.
  - ram_rdata is sampled only at the end of LO and CAP, never while Z.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready at an edge, go to IDLE.
  - rsp_valid is held indefinitely while rsp_ready = 0.
- Latency, with the request accepted at edge 0 and rsp_ready tied high:
  - Store: rsp_valid in cycle 3.
  - Load: rsp_valid in cycle 4.
  - Next request can be accepted at the edge after rsp_valid falls. No overlap between requests.
- addr_hi == addr_lo is legal:
  - Store: the low word overwrites the high word.
  - Load: both halves return the same word.
- Reset asserted mid-transaction: return to IDLE at that edge; in-flight ram_wr/ram_rd drop. A high word already written stays in RAM; no rollback.
- req_valid while not in IDLE is ignored (req_ready = 0). The requester must hold its inputs until accepted.

Optional Feature:
- Macro: RAM_BOUND_CHECK_EN.
- Defined:
  - On accept, if addr_hi >= RAM_DEPTH or addr_lo >= RAM_DEPTH, skip HI/LO/CAP and go straight to RESP.
  - In that response rsp_err = 1 and rsp_rdata = 0; ram_wr/ram_rd stay 0 throughout.
- Undefined:
  - The address is passed through unchecked; the upper address bit is driven as given.
  - rsp_err is constant 0.

Decomposition:
- Package ram_master_pkg holds:
  - state encoding enum {IDLE, HI, LO, CAP, RESP}.
  - ADDR_W/WORD_W defaults and RAM_DEPTH default.
- No sub-module. A single FSM plus capture registers is natural.
- The bench instantiates `ram` and ram_master together.

Test Plan:
- Store 64'h2245_0000_10F0_0010 with hi=0, lo=1 -> ram_wr high exactly 2 cycles, RAM[0] = 32'h2245_0000, RAM[1] = 32'h10F0_0010, rsp_valid in cycle 3, rsp_rdata = 0.
- Load hi=0, lo=1 after the above -> rsp_rdata = 64'h2245_0000_10F0_0010 in cycle 4. ram_rd high in HI and LO only.
- Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, second req_valid ignored. Then rsp_ready = 1 -> IDLE next cycle.
- Store hi=5, lo=5 with 64'hAAAA_AAAA_5555_5555, then load hi=5, lo=5 -> 64'h5555_5555_5555_5555.
- reset_n = 0 during LO of a store of 64'h1111_1111_2222_2222 to hi=8, lo=9 -> next cycle IDLE, all outputs at reset values, RAM[8] = 32'h1111_1111, RAM[9] unchanged.
- RAM_BOUND_CHECK_EN defined, load hi=9'h100 -> rsp_err = 1, rsp_rdata = 0, no ram_rd/ram_wr pulse, rsp_valid in cycle 1.

Source files
------------

// File: rtl/ram_master_pkg.sv
// Shared definitions for ram_master: default geometry of the 256x32 RAM and the
// controller's state encoding.
package ram_master_pkg;

  localparam int ADDR_W_DEF    = 9;
  localparam int WORD_W_DEF    = 32;
  localparam int RAM_DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_e;

endpackage

// File: rtl/ram_master.sv
// 64-bit load/store controller that splits each request into two 32-bit accesses
// (high word first) on the single-port RAM. Optional macro: RAM_BOUND_CHECK_EN.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr_hi,
  input  logic [ADDR_W-1:0]     req_addr_lo,
  input  logic [2*WORD_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WORD_W-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wr,
  output logic [WORD_W-1:0]     ram_wdata,
  output logic                  ram_rd,
  input  logic [WORD_W-1:0]     ram_rdata
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // requester holds its inputs until accepted, and the response is held until taken.

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_HI   = HI;
  localparam logic [2:0] S_LO   = LO;
  localparam logic [2:0] S_CAP  = CAP;
  localparam logic [2:0] S_RESP = RESP;

  logic [2:0]          state;
  logic                we_q;
  logic [ADDR_W-1:0]   hi_q;
  logic [ADDR_W-1:0]   lo_q;
  logic [2*WORD_W-1:0] wdata_q;
  logic [2*WORD_W-1:0] rdata_q;
  logic                out_of_range;

`ifdef RAM_BOUND_CHECK_EN
  logic err_q;
  assign out_of_range = (int'(req_addr_hi) >= RAM_DEPTH) || (int'(req_addr_lo) >= RAM_DEPTH);
  assign rsp_err      = err_q;

  always_ff @(posedge clock) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (state == S_IDLE && req_valid)
      err_q <= out_of_range;
  end
`else
  assign out_of_range = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            hi_q    <= req_addr_hi;
            lo_q    <= req_addr_lo;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            state   <= out_of_range ? S_RESP : S_HI;
          end
        end
        S_HI: state <= S_LO;
        S_LO: begin
          if (we_q) begin
            state <= S_RESP;
          end else begin
            // RAM output reflects the HI read issued one edge earlier
            rdata_q[2*WORD_W-1:WORD_W] <= ram_rdata;
            state                      <= S_CAP;
          end
        end
        S_CAP: begin
          rdata_q[WORD_W-1:0] <= ram_rdata;
          state               <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode from state only; reset_n gating lets a reset drop them at once
  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    rsp_rdata = rdata_q;
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    ram_wdata = '0;
    if (state == S_HI) begin
      ram_addr = hi_q;
      ram_wr   = we_q & reset_n;
      ram_rd   = ~we_q & reset_n;
      if (we_q) ram_wdata = wdata_q[2*WORD_W-1:WORD_W];
    end else if (state == S_LO) begin
      ram_addr = lo_q;
      ram_wr   = we_q & reset_n;
      ram_rd   = ~we_q & reset_n;
      if (we_q) ram_wdata = wdata_q[WORD_W-1:0];
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master with a behavioural 256x32 RAM (registered read, Z when idle).
// Works with and without RAM_BOUND_CHECK_EN defined.
module tb_ram_master;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr_hi;
  logic [8:0]  req_addr_lo;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [8:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic        ram_rd;
  wire  [31:0] ram_rdata;

  ram_master dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr_hi(req_addr_hi), .req_addr_lo(req_addr_lo), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rd(ram_rd),
    .ram_rdata(ram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [31:0] mem [256];
  logic [31:0] ram_q;
  logic        ram_rd_q;
  logic        mem_init;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ram_wr) begin
      mem[ram_addr[7:0]] <= ram_wdata;
    end
    if (ram_rd) ram_q <= mem[ram_addr[7:0]];
    ram_rd_q <= ram_rd;
  end

  assign ram_rdata = ram_rd_q ? ram_q : 32'bz;

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_fail;
  logic [63:0] exp_q[$];
  logic [31:0] ref_mem [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic we, input logic [8:0] hi, input logic [8:0] lo,
                         input logic [63:0] wd, input int hold,
                         output logic [63:0] rdata, output logic err, output int lat,
                         output int n_wr, output int n_rd, output logic [8:0] first_addr);
    bit seen;
    @(negedge clock);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_addr_hi = hi; req_addr_lo = lo; req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clock); #1;
    req_valid   = 1'b0;
    req_we      = 1'($urandom);
    req_addr_hi = 9'($urandom);
    req_addr_lo = 9'($urandom);
    req_wdata   = {$urandom, $urandom};
    lat = 0; n_wr = 0; n_rd = 0; seen = 0; first_addr = '0;
    do begin
      @(negedge clock);
      lat++;
      if (ram_wr) n_wr++;
      if (ram_rd) n_rd++;
      if ((ram_wr || ram_rd) && !seen) begin
        seen = 1;
        first_addr = ram_addr;
      end
    end while (!rsp_valid && lat < 20);
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    // a stray store is offered while the response waits; it must be ignored
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr_hi = 9'd0; req_addr_lo = 9'd1;
      req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clock);
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_rdata", rsp_rdata, rdata);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check("hold_ram_quiet", {62'd0, ram_wr, ram_rd}, 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("post_rsp_idle", {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  task automatic do_txn(input logic we, input logic [8:0] hi, input logic [8:0] lo,
                        input logic [63:0] wd, input int hold, input string tag,
                        output logic [63:0] rd);
    logic       err;
    int         lat, nwr, nrd;
    logic [8:0] fa;
    bit         oob;
    oob = 0;
`ifdef RAM_BOUND_CHECK_EN
    oob = (hi >= 9'd256) || (lo >= 9'd256);
`endif
    if (oob) begin
      exp_q.push_back(64'h0);
    end else if (we) begin
      ref_mem[hi[7:0]] = wd[63:32];
      ref_mem[lo[7:0]] = wd[31:0];
      exp_q.push_back(64'h0);
    end else begin
      exp_q.push_back({ref_mem[hi[7:0]], ref_mem[lo[7:0]]});
    end
    run_txn(we, hi, lo, wd, hold, rd, err, lat, nwr, nrd, fa);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, {63'd0, err}, {63'd0, oob});
    check({tag, "_latency"}, 64'(lat), oob ? 64'd1 : (we ? 64'd3 : 64'd4));
    check({tag, "_wr_cycles"}, 64'(nwr), (oob || !we) ? 64'd0 : 64'd2);
    check({tag, "_rd_cycles"}, 64'(nrd), (oob || we) ? 64'd0 : 64'd2);
    if (!oob) check({tag, "_hi_addr_first"}, {55'd0, fa}, {55'd0, hi});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [8:0]  hi;
    logic [8:0]  lo;
    logic [63:0] wd;
    int          hold;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] rd;
    logic [31:0] old9;
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    reset_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr_hi = '0; req_addr_lo = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 9'd0, 9'd1, 64'h2245_0000_10F0_0010, 0, 64'h0};
    vecs[1] = '{1'b0, 9'd0, 9'd1, 64'h0,                   0, 64'h2245_0000_10F0_0010};
    vecs[2] = '{1'b0, 9'd0, 9'd1, 64'h0,                   5, 64'h2245_0000_10F0_0010};
    vecs[3] = '{1'b1, 9'd5, 9'd5, 64'hAAAA_AAAA_5555_5555, 0, 64'h0};
    vecs[4] = '{1'b0, 9'd5, 9'd5, 64'h0,                   0, 64'h5555_5555_5555_5555};
    vecs[5] = '{1'b0, 9'd1, 9'd0, 64'h0,                   2, 64'h10F0_0010_2245_0000};

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1; mem_init = 1'b0;

    @(negedge clock);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_rsp", {rsp_rdata[62:0], rsp_valid} | {63'd0, rsp_err}, 64'd0);
    check("reset_ram_pins", {22'd0, ram_addr, ram_wdata, ram_wr, ram_rd}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].we, vecs[i].hi, vecs[i].lo, vecs[i].wd, vecs[i].hold, $sformatf("vec%0d", i), rd);
      check($sformatf("vec%0d_table", i), rd, vecs[i].exp_rdata);
      if (i == 0) begin
        check("vec0_ram0", {32'd0, mem[0]}, 64'h2245_0000);
        check("vec0_ram1", {32'd0, mem[1]}, 64'h10F0_0010);
      end
    end

    // reset arriving during LO of a store: high word stays written, low word never lands
    old9 = mem[9];
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr_hi = 9'd8; req_addr_lo = 9'd9;
    req_wdata = 64'h1111_1111_2222_2222; rsp_ready = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1 reset_n = 1'b0;
    @(negedge clock);
    check("rst_lo_wr_dropped", {63'd0, ram_wr}, 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_idle", {62'd0, rsp_valid, rsp_err}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_ram_pins", {22'd0, ram_addr, ram_wdata, ram_wr, ram_rd}, 64'd0);
    check("rst_ram8", {32'd0, mem[8]}, 64'h1111_1111);
    check("rst_ram9", {32'd0, mem[9]}, {32'd0, old9});
    ref_mem[8] = 32'h1111_1111;

    // upper address bit: rejected with the bound check, passed through without it
    do_txn(1'b0, 9'h100, 9'd2, 64'h0, 0, "hi_256", rd);
    do_txn(1'b1, 9'd3, 9'h1FF, 64'h0123_4567_89AB_CDEF, 1, "lo_511", rd);

    for (int i = 0; i < 40; i++) begin
      logic [8:0] hi, lo;
      hi = 9'($urandom_range(0, 15));
      lo = ($urandom_range(0, 3) == 0) ? hi : 9'($urandom_range(0, 15));
`ifdef RAM_BOUND_CHECK_EN
      if ($urandom_range(0, 7) == 0) hi = 9'($urandom_range(256, 511));
`endif
      do_txn(1'($urandom), hi, lo, {$urandom, $urandom}, $urandom_range(0, 3),
             $sformatf("rnd%0d", i), rd);
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("final_ram%0d", i), {32'd0, mem[i]}, {32'd0, ref_mem[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
